boot_segment_loader: RTL and testbench

Parametrised boot-image transfer engine for the core top level. It copies one or more byte segments from a synchronous boot ROM into the core's download port (`dn_go`/`dn_wr`/`dn_addr`/`dn_data`), then issues a single-cycle execute request at a configurable entry address. It generalises the fixed single-image loader in three ways: multiple segments, configurable ROM read latency, and a `dn_wait` back-pressure handshake. It sits between the boot ROM and `pcw_core`, clocked by `clk_sys`.

---
 rtl/boot_segment_loader.sv | 226 ++++++++++++++++++++++
 tb/tb_boot_segment_loader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_segment_loader.sv
// boot_segment_loader: copies byte segments from a synchronous boot ROM into
// the core download port, then issues a one-cycle execute request.
// Optional feature macro: BOOT_LOADER_CHECKSUM_EN (per-segment 16-bit checksum).
module boot_segment_loader #(
    parameter int ADDR_W      = 16,
    parameter int SRC_AW      = 9,
    parameter int DATA_W      = 8,
    parameter int SEG_COUNT   = 2,
    parameter int ROM_LATENCY = 1,
    parameter int AUTO_START  = 1
) (
    input  logic                          clk_sys,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic [SEG_COUNT*SRC_AW-1:0]   seg_src,
    input  logic [SEG_COUNT*ADDR_W-1:0]   seg_dst,
    input  logic [SEG_COUNT*(SRC_AW+1)-1:0] seg_len,
`ifdef BOOT_LOADER_CHECKSUM_EN
    input  logic [SEG_COUNT*16-1:0]       seg_sum,
`endif
    input  logic [ADDR_W-1:0]             entry_addr,
    output logic [SRC_AW-1:0]             rom_addr,
    input  logic [DATA_W-1:0]             rom_data,
    output logic                          dn_go,
    output logic                          dn_wr,
    output logic [ADDR_W-1:0]             dn_addr,
    output logic [DATA_W-1:0]             dn_data,
    input  logic                          dn_wait,
    output logic                          execute_enable,
    output logic [ADDR_W-1:0]             execute_addr,
    output logic                          busy,
    output logic                          done,
    output logic                          error
);

    localparam int LEN_W      = SRC_AW + 1;
    localparam int SEG_W      = 4;
    localparam int LAT_CYCLES = (ROM_LATENCY == 0) ? 1 : ROM_LATENCY;
    localparam logic [SEG_W-1:0] SEG_END = SEG_W'(SEG_COUNT);
    localparam logic [1:0]       LAT_END = 2'(LAT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SEG, RD, LAT, WR, EXEC} state_t;

    state_t state, state_next;

    logic                          start_q;
    logic                          auto_pend;
    logic                          start_req;
    logic [SEG_COUNT*SRC_AW-1:0]   src_q;
    logic [SEG_COUNT*ADDR_W-1:0]   dst_q;
    logic [SEG_COUNT*LEN_W-1:0]    len_q;
    logic [ADDR_W-1:0]             entry_q;
    logic [SEG_W-1:0]              seg;
    logic [SEG_W-1:0]              seg_sel;
    logic [LEN_W-1:0]              cnt;
    logic [1:0]                    lat_cnt;
    logic [SRC_AW-1:0]             cur_src;
    logic [ADDR_W-1:0]             cur_dst;
    logic [LEN_W-1:0]              cur_len;
    logic                          seg_end;
    logic                          last_byte;
    logic                          wr_done;
    logic                          sum_ok;
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [SEG_COUNT*16-1:0]       sum_q;
    logic [15:0]                   sum;
    logic [15:0]                   sum_next;
    logic                          error_q;
`endif

    assign dn_wr          = (state == WR);
    assign execute_enable = (state == EXEC);
    assign busy           = (state != IDLE);

    // Select the active segment descriptor and derive per-byte status flags.
    always_comb begin
        seg_sel   = (seg < SEG_END) ? seg : '0;
        cur_src   = src_q[seg_sel*SRC_AW +: SRC_AW];
        cur_dst   = dst_q[seg_sel*ADDR_W +: ADDR_W];
        cur_len   = len_q[seg_sel*LEN_W +: LEN_W];
        seg_end   = (seg == SEG_END);
        last_byte = (cnt == cur_len - 1'b1);
        wr_done   = (state == WR) && !dn_wait;
        start_req = (start && !start_q) || auto_pend;
`ifdef BOOT_LOADER_CHECKSUM_EN
        sum_next  = sum + 16'(dn_data);
        sum_ok    = (sum_next == sum_q[seg_sel*16 +: 16]);
`else
        sum_ok    = 1'b1;
`endif
    end

    // Next-state logic of the transfer sequencer.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start_req) state_next = SEG;
            SEG: begin
                if (seg_end)
                    state_next = EXEC;
                else if (cur_len != '0)
                    state_next = RD;
            end
            RD:  state_next = LAT;
            LAT: if (lat_cnt == LAT_END) state_next = WR;
            WR: begin
                if (wr_done) begin
                    if (!last_byte)
                        state_next = RD;
                    else if (sum_ok)
                        state_next = SEG;
                    else
                        state_next = IDLE;
                end
            end
            EXEC:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register; reset aborts any transfer in flight.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Datapath: descriptor latches, counters, ROM address and download outputs.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            start_q      <= 1'b0;
            auto_pend    <= (AUTO_START != 0);
            src_q        <= '0;
            dst_q        <= '0;
            len_q        <= '0;
            entry_q      <= '0;
            seg          <= '0;
            cnt          <= '0;
            lat_cnt      <= '0;
            rom_addr     <= '0;
            dn_go        <= 1'b0;
            dn_addr      <= '0;
            dn_data      <= '0;
            execute_addr <= '0;
            done         <= 1'b0;
        end else begin
            start_q   <= start;
            auto_pend <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_req) begin
                        src_q        <= seg_src;
                        dst_q        <= seg_dst;
                        len_q        <= seg_len;
                        entry_q      <= entry_addr;
                        seg          <= '0;
                        done         <= 1'b0;
                        dn_go        <= 1'b1;
                        execute_addr <= '0;
                    end
                end
                SEG: begin
                    if (seg_end) begin
                        dn_go        <= 1'b0;
                        execute_addr <= entry_q;
                    end else if (cur_len == '0) begin
                        seg <= seg + 1'b1;
                    end else begin
                        cnt      <= '0;
                        lat_cnt  <= '0;
                        rom_addr <= cur_src;
                    end
                end
                LAT: begin
                    lat_cnt <= lat_cnt + 1'b1;
                    if (lat_cnt == LAT_END) begin
                        dn_data <= rom_data;
                        dn_addr <= cur_dst + ADDR_W'(cnt);
                    end
                end
                WR: begin
                    if (wr_done) begin
                        cnt     <= cnt + 1'b1;
                        lat_cnt <= '0;
                        if (last_byte) begin
                            seg <= seg + 1'b1;
                            if (!sum_ok) dn_go <= 1'b0;
                        end else begin
                            rom_addr <= cur_src + SRC_AW'(cnt + 1'b1);
                        end
                    end
                end
                EXEC: done <= 1'b1;
                default: ;
            endcase
        end
    end

`ifdef BOOT_LOADER_CHECKSUM_EN
    // Running per-segment checksum and sticky error flag.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sum_q   <= '0;
            sum     <= '0;
            error_q <= 1'b0;
        end else begin
            if (state == IDLE && start_req) begin
                sum_q   <= seg_sum;
                error_q <= 1'b0;
            end
            if (state == SEG)
                sum <= '0;
            if (wr_done) begin
                sum <= sum_next;
                if (last_byte && !sum_ok) error_q <= 1'b1;
            end
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_boot_segment_loader.sv
// Self-checking bench for boot_segment_loader (SEG_COUNT=2, ROM_LATENCY=1,
// AUTO_START=1). Expected writes are queued when a transfer is set up and
// compared as the loader completes each write.
module tb_boot_segment_loader;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        start   = 1'b0;
    logic        dn_wait = 1'b0;
    logic [17:0] seg_src = '0;
    logic [31:0] seg_dst = '0;
    logic [19:0] seg_len = '0;
    logic [15:0] entry_addr = '0;
    logic [8:0]  rom_addr;
    logic [7:0]  rom_data = '0;
    logic        dn_go;
    logic        dn_wr;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        execute_enable;
    logic [15:0] execute_addr;
    logic        busy;
    logic        done;
    logic        error;
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [31:0] seg_sum = '0;
`endif

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t         sbQueue[$];
    logic [7:0]  romMem [512];
    int          checkCount = 0;
    int          failCount  = 0;
    int          expExec;

    boot_segment_loader #(
        .ADDR_W(16), .SRC_AW(9), .DATA_W(8),
        .SEG_COUNT(2), .ROM_LATENCY(1), .AUTO_START(1)
    ) dut (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .start(start),
        .seg_src(seg_src),
        .seg_dst(seg_dst),
        .seg_len(seg_len),
`ifdef BOOT_LOADER_CHECKSUM_EN
        .seg_sum(seg_sum),
`endif
        .entry_addr(entry_addr),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .dn_go(dn_go),
        .dn_wr(dn_wr),
        .dn_addr(dn_addr),
        .dn_data(dn_data),
        .dn_wait(dn_wait),
        .execute_enable(execute_enable),
        .execute_addr(execute_addr),
        .busy(busy),
        .done(done),
        .error(error)
    );

    always #5 clk_sys = ~clk_sys;

    // Synchronous ROM with one cycle of read latency.
    always @(posedge clk_sys) rom_data <= romMem[rom_addr];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic pushSegment(input logic [8:0] src, input logic [15:0] dst, input logic [9:0] len);
        for (int i = 0; i < int'(len); i++) begin
            wr_t w;
            w.addr = dst + 16'(i);
            w.data = romMem[src + 9'(i)];
            sbQueue.push_back(w);
        end
    endtask

    task automatic applyStimulus(input logic [8:0] s0, input logic [15:0] d0, input logic [9:0] l0,
                                 input logic [8:0] s1, input logic [15:0] d1, input logic [9:0] l1,
                                 input logic [15:0] entry, output int execAt);
        seg_src    = {s1, s0};
        seg_dst    = {d1, d0};
        seg_len    = {l1, l0};
        entry_addr = entry;
        sbQueue.delete();
        pushSegment(s0, d0, l0);
        pushSegment(s1, d1, l1);
`ifdef BOOT_LOADER_CHECKSUM_EN
        begin
            logic [15:0] sum0, sum1;
            sum0 = '0;
            sum1 = '0;
            for (int i = 0; i < int'(l0); i++) sum0 += 16'(romMem[s0 + 9'(i)]);
            for (int i = 0; i < int'(l1); i++) sum1 += 16'(romMem[s1 + 9'(i)]);
            seg_sum = {sum1, sum0};
        end
`endif
        execAt = 1 + 3 * (int'(l0) + int'(l1)) + 3;
    endtask

    task automatic runTransfer(input string tag, input int execAt, input logic [15:0] expEntry,
                               input int stallByte, input int stallCycles, input int busyStartAt);
        int          cyc = 0;
        int          writes = 0;
        int          execs = 0;
        int          execCyc = -10;
        int          stallLeft = stallCycles;
        int          expWrites = sbQueue.size();
        int          limit = execAt + stallCycles;
        bit          finished = 0;
        logic [15:0] holdA = '0;
        logic [7:0]  holdD = '0;
        while (!finished) begin
            @(negedge clk_sys);
            cyc++;
            start   = (cyc == busyStartAt);
            dn_wait = 1'b0;
            if (cyc == 1) begin
                checkOutput({tag, "_go_rise"}, dn_go, 1);
                checkOutput({tag, "_done_clear"}, done, 0);
            end
            if (dn_wr) begin
                if (stallCycles > 0 && writes == stallByte) begin
                    if (stallLeft == stallCycles) begin
                        holdA = dn_addr;
                        holdD = dn_data;
                    end else begin
                        checkOutput({tag, "_stall_addr"}, dn_addr, holdA);
                        checkOutput({tag, "_stall_data"}, dn_data, holdD);
                    end
                end
                if (writes == stallByte && stallLeft > 0) begin
                    dn_wait = 1'b1;
                    stallLeft--;
                end else if (sbQueue.size() == 0) begin
                    checkOutput({tag, "_extra_write"}, 1, 0);
                    writes++;
                end else begin
                    wr_t w = sbQueue.pop_front();
                    checkOutput({tag, "_wr_addr"}, dn_addr, w.addr);
                    checkOutput({tag, "_wr_data"}, dn_data, w.data);
                    writes++;
                end
            end
            if (execute_enable) begin
                execs++;
                execCyc = cyc;
                checkOutput({tag, "_exec_cycle"}, cyc, limit);
                checkOutput({tag, "_exec_addr"}, execute_addr, expEntry);
                checkOutput({tag, "_exec_go_low"}, dn_go, 0);
            end
            if (execs > 0 && cyc == execCyc + 1) begin
                checkOutput({tag, "_done_set"}, done, 1);
                checkOutput({tag, "_idle"}, busy, 0);
                finished = 1;
            end
            if (!finished && cyc > limit + 40) begin
                checkOutput({tag, "_timeout"}, 0, 1);
                finished = 1;
            end
        end
        start   = 1'b0;
        dn_wait = 1'b0;
        checkOutput({tag, "_write_count"}, writes, expWrites);
        checkOutput({tag, "_exec_count"}, execs, 1);
        checkOutput({tag, "_error"}, error, 0);
    endtask

    initial begin
        int sawExec;
        for (int i = 0; i < 512; i++) romMem[i] = 8'(i * 37 + (i >> 4) + 5);

        // Reset values, then auto-start of a single 276-byte image.
        reset_n = 1'b0;
        applyStimulus(9'h000, 16'h0000, 10'd276, 9'h000, 16'h0000, 10'd0, 16'h0000, expExec);
        repeat (3) @(negedge clk_sys);
        checkOutput("rst_dn_go", dn_go, 0);
        checkOutput("rst_dn_wr", dn_wr, 0);
        checkOutput("rst_exec_en", execute_enable, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_error", error, 0);
        checkOutput("rst_rom_addr", rom_addr, 0);
        checkOutput("rst_dn_addr", dn_addr, 0);
        checkOutput("rst_exec_addr", execute_addr, 0);
        reset_n = 1'b1;
        runTransfer("single", expExec, 16'h0000, -1, 0, 0);

        // Two segments with a five-cycle stall on byte 10.
        applyStimulus(9'h020, 16'h4000, 10'd20, 9'h040, 16'h5000, 10'd3, 16'h1234, expExec);
        @(negedge clk_sys);
        start = 1'b1;
        runTransfer("stall", expExec, 16'h1234, 10, 5, 0);

        // Skipped segment, destination wrap, and a start edge while busy.
        applyStimulus(9'h000, 16'h0000, 10'd0, 9'h100, 16'hFFFE, 10'd4, 16'hBEEF, expExec);
        @(negedge clk_sys);
        start = 1'b1;
        runTransfer("wrap_busy", expExec, 16'hBEEF, -1, 0, 8);

        // Source address wrap across the top of the ROM.
        applyStimulus(9'h1FE, 16'h0200, 10'd3, 9'h005, 16'h0300, 10'd2, 16'h0ABC, expExec);
        @(negedge clk_sys);
        start = 1'b1;
        runTransfer("src_wrap", expExec, 16'h0ABC, -1, 0, 0);

        // Reset mid-segment, then auto-restart from byte 0.
        applyStimulus(9'h010, 16'h3000, 10'd30, 9'h080, 16'h3800, 10'd5, 16'h2222, expExec);
        @(negedge clk_sys);
        start = 1'b1;
        sawExec = 0;
        repeat (40) begin
            @(negedge clk_sys);
            start = 1'b0;
            if (execute_enable) sawExec++;
        end
        reset_n = 1'b0;
        #1;
        checkOutput("abort_dn_go", dn_go, 0);
        checkOutput("abort_dn_wr", dn_wr, 0);
        checkOutput("abort_dn_addr", dn_addr, 0);
        checkOutput("abort_dn_data", dn_data, 0);
        checkOutput("abort_rom_addr", rom_addr, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_exec_en", execute_enable, 0);
        checkOutput("abort_no_exec", sawExec, 0);
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        runTransfer("restart", expExec, 16'h2222, -1, 0, 0);

`ifdef BOOT_LOADER_CHECKSUM_EN
        // Corrupted checksum on segment 1: error, no execute, done stays low.
        applyStimulus(9'h030, 16'h6000, 10'd4, 9'h050, 16'h6100, 10'd4, 16'h4444, expExec);
        seg_sum[31:16] = seg_sum[31:16] + 16'd1;
        @(negedge clk_sys);
        start = 1'b1;
        sawExec = 0;
        for (int c = 1; c <= expExec + 20; c++) begin
            @(negedge clk_sys);
            start = 1'b0;
            if (execute_enable) sawExec++;
            if (c > 1 && !busy) break;
        end
        checkOutput("sum_busy_end", busy, 0);
        checkOutput("sum_error", error, 1);
        checkOutput("sum_done", done, 0);
        checkOutput("sum_no_exec", sawExec, 0);
        checkOutput("sum_dn_go", dn_go, 0);
        sbQueue.delete();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
